dram_frame_reader: RTL and testbench
====================================

Name: dram_frame_reader

Overview:
- Parametrised frame-read engine. Walks one frame buffer in DRAM as a series of burst reads and buffers the returned words in an internal synchronous data FIFO.
- Publishes the word offset of each issued burst through a companion offset FIFO so downstream pixel logic can place the data.
- Sits between the DRAM read-command port and the video/stream output stage.
- Adds single-shot or continuous frame looping, a shortened final burst, credit-gated issue, and sticky error reporting.

Parameters:
DATA_W, 32, width of DRAM read word and data FIFO entry
ADDR_W, 32, DRAM byte-address width
BURST_LEN, 64, words per full burst (power of two, <= FIFO_DEPTH/2)
FRAME_WORDS, 1440000, words per frame (1600x900)
BYTES_PER_WORD, 4, byte-address scaling of word offset (power of two)
BASE0, 32'h0000_0000, frame buffer 0 byte base
BASE1, 32'h0100_0000, frame buffer 1 byte base
FIFO_DEPTH, 2048, data FIFO depth in words (power of two)
OFF_DEPTH, 16, offset FIFO depth in entries (power of two)

Ports:
clk  in  1  clock; all ports synchronous to clk
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a frame when idle
frame_sel  in  1  0 selects BASE0, 1 selects BASE1; sampled at each frame start
continuous  in  1  1 restarts the next frame automatically after completion; sampled at each frame end
kick  out  1  read-request strobe, held until acknowledged
busy  in  1  DRAM reader busy; high acknowledges kick
read_num  out  32  words requested by the current burst
read_addr  out  ADDR_W  byte address of the current burst
rd_data  in  DATA_W  returned read word
rd_valid  in  1  rd_data valid this cycle
pix_rd  in  1  pop from data FIFO
pix_out  out  DATA_W  data FIFO head (first-word-fall-through)
pix_empty  out  1  data FIFO empty
pix_cnt  out  $clog2(FIFO_DEPTH)+1  data FIFO occupancy
off_rd  in  1  pop from offset FIFO
off_out  out  32  offset FIFO head (word offset of the burst)
off_empty  out  1  offset FIFO empty
active  out  1  a frame is in progress
frame_done  out  1  one-cycle pulse at completion of each frame
err  out  1  sticky error flag; cleared only by rst

Behaviour:
- Reset values: kick=0, active=0, frame_done=0, err=0, both FIFOs empty (pix_empty=1, off_empty=1, pix_cnt=0), offset=0, state IDLE.
- rst mid-operation aborts the current burst. Outstanding data arriving after reset is dropped without setting err.
- FSM states: IDLE, ISSUE, ACK, DATA, DONE.
- IDLE: on start, latch the base from frame_sel, set offset=0, go to ISSUE, active=1. A start pulse outside IDLE is ignored.
- ISSUE: burst length len = min(BURST_LEN, FRAME_WORDS-offset).
  - Wait until data FIFO free space >= len (counting words already in flight), offset FIFO not full, and busy=0.
  - Then assert kick and go to ACK.
- read_addr = base + offset*BYTES_PER_WORD. read_addr and read_num = len are held stable while kick=1.
- ACK: keep kick=1 until a cycle with busy=1. In that cycle: kick drops next cycle, push offset to the offset FIFO, offset += len, rx_cnt = 0, go to DATA.
- DATA: each rd_valid pushes rd_data and increments rx_cnt. When rx_cnt reaches len:
  - offset == FRAME_WORDS goes to DONE;
  - otherwise go to ISSUE.
- DONE: pulse frame_done for one cycle.
  - If continuous=1, re-sample frame_sel, set offset=0, go to ISSUE; active stays 1.
  - Otherwise active=0, go to IDLE.
- Error conditions (all set err=1):
  - rd_valid outside DATA: word dropped;
  - rd_valid with the data FIFO full: word dropped;
  - pix_rd while pix_empty: pop ignored;
  - off_rd while off_empty: pop ignored.
- Simultaneous push and pop on either FIFO is legal; occupancy is unchanged.
- pix_cnt reflects the registered occupancy one cycle after a push or pop.
- Last burst of a frame: read_num = FRAME_WORDS mod BURST_LEN when nonzero.
- Offset arithmetic is 32-bit; no wrap is possible because offset never exceeds FRAME_WORDS.

Test Plan:
- FRAME_WORDS=200, BURST_LEN=64, frame_sel=1, start, DRAM model returns words immediately -> read_addr sequence 0x0100_0000, 0x0100_0100, 0x0100_0200, 0x0100_0300; read_num 64,64,64,8; off_out 0,64,128,192; one frame_done pulse; active then 0.
- DRAM model holds busy=0 for 5 cycles after kick -> kick stays 1 for all 5 cycles with stable read_addr; exactly one offset push per burst.
- FIFO_DEPTH=128, no pix_rd -> second burst issues, third kick withheld (free space 0 < 64); popping 64 words re-enables kick within 2 cycles.
- continuous=1, frame_sel toggled 0->1 during frame 1 -> frame 2 bursts use BASE1, offset restarts at 0, two frame_done pulses, active stays high.
- rd_valid injected in IDLE, and pix_rd issued while pix_empty -> err=1 and stays 1; pix_cnt unchanged; err cleared only by rst.
- rst asserted mid-DATA with 20 of 64 words received -> next cycle kick=0, pix_cnt=0, off_empty=1, state IDLE; late rd_valid after reset leaves err=0.

Source files
------------

// File: rtl/dram_frame_reader.sv
// dram_frame_reader
// Walks one frame buffer in DRAM as a sequence of burst reads, buffers the
// returned words in a data FIFO, and publishes the word offset of every
// issued burst through a small offset FIFO for downstream pixel placement.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start                 one-cycle pulse, begins a frame when idle
//   frame_sel             0 = BASE0, 1 = BASE1 (sampled at each frame start)
//   continuous            auto-restart at frame end (sampled at frame end)
//   kick / busy           read-request strobe, acknowledged by busy=1
//   read_num / read_addr  burst length in words / burst byte address
//   rd_data / rd_valid    returned read words
//   pix_rd / pix_out / pix_empty / pix_cnt    data FIFO pop side (FWFT)
//   off_rd / off_out / off_empty              offset FIFO pop side (FWFT)
//   active                a frame is in progress
//   frame_done            one-cycle pulse at the end of each frame
//   err                   sticky protocol error, cleared only by rst
module dram_frame_reader #(
  parameter int                DATA_W         = 32,
  parameter int                ADDR_W         = 32,
  parameter int                BURST_LEN      = 64,
  parameter int                FRAME_WORDS    = 1440000,
  parameter int                BYTES_PER_WORD = 4,
  parameter logic [ADDR_W-1:0] BASE0          = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] BASE1          = 32'h0100_0000,
  parameter int                FIFO_DEPTH     = 2048,
  parameter int                OFF_DEPTH      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         frame_sel,
  input  logic                         continuous,
  output logic                         kick,
  input  logic                         busy,
  output logic [31:0]                  read_num,
  output logic [ADDR_W-1:0]            read_addr,
  input  logic [DATA_W-1:0]            rd_data,
  input  logic                         rd_valid,
  input  logic                         pix_rd,
  output logic [DATA_W-1:0]            pix_out,
  output logic                         pix_empty,
  output logic [$clog2(FIFO_DEPTH):0]  pix_cnt,
  input  logic                         off_rd,
  output logic [31:0]                  off_out,
  output logic                         off_empty,
  output logic                         active,
  output logic                         frame_done,
  output logic                         err
);

  localparam int PAW       = $clog2(FIFO_DEPTH);
  localparam int PCW       = PAW + 1;
  localparam int OAW       = $clog2(OFF_DEPTH);
  localparam int OCW       = OAW + 1;
  localparam int BPW_SHIFT = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {IDLE, ISSUE, ACK, DATA, DONE} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   base_q;
  logic [31:0]         offset_q;
  logic [31:0]         rx_cnt_q;
  logic                kick_q;
  logic [31:0]         read_num_q;
  logic [ADDR_W-1:0]   read_addr_q;
  logic                active_q;
  logic                frame_done_q;
  logic                err_q;
  // Set by reset, cleared by the next start: words still in flight from an
  // aborted burst may arrive while idle and must be dropped silently.
  logic                drain_q;

  // Data FIFO state
  logic [DATA_W-1:0]   pmem [FIFO_DEPTH];
  logic [PAW-1:0]      pwr_q, prd_q, prd_d;
  logic [PCW-1:0]      pcnt_q;
  logic [DATA_W-1:0]   phead_q;
  logic                pix_full, pix_push, pix_pop;

  // Offset FIFO state
  logic [31:0]         omem [OFF_DEPTH];
  logic [OAW-1:0]      owr_q, ord_q, ord_d;
  logic [OCW-1:0]      ocnt_q;
  logic [31:0]         ohead_q;
  logic                off_full, off_push, off_pop;

  // Burst sizing and credit check
  logic [31:0]         remaining;
  logic [31:0]         len;
  logic [PCW-1:0]      pix_free;
  logic                credit_ok;
  logic [ADDR_W-1:0]   addr_now;

  assign remaining = 32'(FRAME_WORDS) - offset_q;
  assign len       = (remaining < 32'(BURST_LEN)) ? remaining : 32'(BURST_LEN);
  // Only one burst is ever outstanding and ISSUE is entered after it has
  // fully landed, so occupancy alone already accounts for in-flight words.
  assign pix_free  = PCW'(FIFO_DEPTH) - pcnt_q;
  assign credit_ok = (32'(pix_free) >= len) && !off_full && !busy;
  assign addr_now  = base_q + (ADDR_W'(offset_q) << BPW_SHIFT);

  assign pix_full  = (pcnt_q == PCW'(FIFO_DEPTH));
  assign pix_empty = (pcnt_q == '0);
  assign pix_push  = (state_q == DATA) && rd_valid && !pix_full;
  assign pix_pop   = pix_rd && !pix_empty;
  assign prd_d     = pix_pop ? prd_q + PAW'(1) : prd_q;

  assign off_full  = (ocnt_q == OCW'(OFF_DEPTH));
  assign off_empty = (ocnt_q == '0);
  assign off_push  = (state_q == ACK) && busy && !off_full;
  assign off_pop   = off_rd && !off_empty;
  assign ord_d     = off_pop ? ord_q + OAW'(1) : ord_q;

  assign kick       = kick_q;
  assign read_num   = read_num_q;
  assign read_addr  = read_addr_q;
  assign active     = active_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
  assign pix_out    = phead_q;
  assign pix_cnt    = pcnt_q;
  assign off_out    = ohead_q;

  // Control FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      base_q       <= BASE0;
      offset_q     <= '0;
      rx_cnt_q     <= '0;
      kick_q       <= 1'b0;
      read_num_q   <= '0;
      read_addr_q  <= '0;
      active_q     <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      drain_q      <= 1'b1;
    end else begin
      frame_done_q <= 1'b0;

      if ((pix_rd && pix_empty) || (off_rd && off_empty) ||
          (rd_valid && (state_q == DATA) && pix_full) ||
          (rd_valid && (state_q != DATA) && !drain_q))
        err_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (start) begin
            base_q   <= frame_sel ? BASE1 : BASE0;
            offset_q <= '0;
            active_q <= 1'b1;
            drain_q  <= 1'b0;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          if (credit_ok) begin
            kick_q      <= 1'b1;
            read_num_q  <= len;
            read_addr_q <= addr_now;
            state_q     <= ACK;
          end
        end
        ACK: begin
          if (busy) begin
            kick_q   <= 1'b0;
            offset_q <= offset_q + read_num_q;
            rx_cnt_q <= '0;
            state_q  <= DATA;
          end
        end
        DATA: begin
          if (rd_valid) begin
            rx_cnt_q <= rx_cnt_q + 32'd1;
            if (rx_cnt_q + 32'd1 == read_num_q) begin
              if (offset_q == 32'(FRAME_WORDS)) begin
                frame_done_q <= 1'b1;
                state_q      <= DONE;
              end else begin
                state_q <= ISSUE;
              end
            end
          end
        end
        DONE: begin
          if (continuous) begin
            base_q   <= frame_sel ? BASE1 : BASE0;
            offset_q <= '0;
            state_q  <= ISSUE;
          end else begin
            active_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Data FIFO: RAM read is registered at the post-pop pointer so the head
  // register always holds the entry at prd_q (first-word-fall-through).
  always_ff @(posedge clk) begin
    if (pix_push)
      pmem[pwr_q] <= rd_data;
  end

  always_ff @(posedge clk) begin
    // Bypass covers a write landing on the slot that becomes the head.
    if (pix_push && (pwr_q == prd_d))
      phead_q <= rd_data;
    else
      phead_q <= pmem[prd_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwr_q  <= '0;
      prd_q  <= '0;
      pcnt_q <= '0;
    end else begin
      prd_q <= prd_d;
      if (pix_push)
        pwr_q <= pwr_q + PAW'(1);
      case ({pix_push, pix_pop})
        2'b10:   pcnt_q <= pcnt_q + PCW'(1);
        2'b01:   pcnt_q <= pcnt_q - PCW'(1);
        default: pcnt_q <= pcnt_q;
      endcase
    end
  end

  // Offset FIFO, same structure as the data FIFO.
  always_ff @(posedge clk) begin
    if (off_push)
      omem[owr_q] <= offset_q;
  end

  always_ff @(posedge clk) begin
    if (off_push && (owr_q == ord_d))
      ohead_q <= offset_q;
    else
      ohead_q <= omem[ord_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owr_q  <= '0;
      ord_q  <= '0;
      ocnt_q <= '0;
    end else begin
      ord_q <= ord_d;
      if (off_push)
        owr_q <= owr_q + OAW'(1);
      case ({off_push, off_pop})
        2'b10:   ocnt_q <= ocnt_q + OCW'(1);
        2'b01:   ocnt_q <= ocnt_q - OCW'(1);
        default: ocnt_q <= ocnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_frame_reader.sv
module tb_dram_frame_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, frame_sel, continuous;
  logic        kick, busy;
  logic [31:0] read_num, read_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        pix_rd;
  logic [31:0] pix_out;
  logic        pix_empty;
  logic [7:0]  pix_cnt;
  logic        off_rd;
  logic [31:0] off_out;
  logic        off_empty;
  logic        active, frame_done, err;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int wid    = 0;  // next word id returned by the DRAM model
  int rid    = 0;  // next word id expected at the data FIFO head

  always #5 clk = ~clk;

  dram_frame_reader #(
    .DATA_W(32), .ADDR_W(32), .BURST_LEN(64), .FRAME_WORDS(200),
    .BYTES_PER_WORD(4), .BASE0(32'h0000_0000), .BASE1(32'h0100_0000),
    .FIFO_DEPTH(128), .OFF_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .frame_sel(frame_sel),
    .continuous(continuous), .kick(kick), .busy(busy), .read_num(read_num),
    .read_addr(read_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .pix_rd(pix_rd), .pix_out(pix_out), .pix_empty(pix_empty),
    .pix_cnt(pix_cnt), .off_rd(off_rd), .off_out(off_out),
    .off_empty(off_empty), .active(active), .frame_done(frame_done),
    .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_kick(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (kick) break;
      tick();
    end
    chk("kick_seen", 32'(kick), 32'd1);
  endtask

  // DRAM model for one burst: check the request, hold busy low for
  // 'delay' cycles, acknowledge, then return every word back to back.
  task automatic serve(input logic [31:0] addr, input logic [31:0] num,
                       input logic [31:0] off, input int delay);
    wait_kick(20);
    chk("read_addr", read_addr, addr);
    chk("read_num", read_num, num);
    for (int d = 0; d < delay; d++) begin
      tick();
      chk("kick_hold", 32'(kick), 32'd1);
      chk("addr_stable", read_addr, addr);
    end
    busy = 1'b1;
    tick();
    busy = 1'b0;
    chk("kick_drop", 32'(kick), 32'd0);
    chk("off_nonempty", 32'(off_empty), 32'd0);
    chk("off_out", off_out, off);
    for (int i = 0; i < int'(num); i++) begin
      rd_data  = 32'hA000_0000 + 32'(wid);
      wid++;
      rd_valid = 1'b1;
      off_rd   = (i == 0);
      tick();
    end
    rd_valid = 1'b0;
    off_rd   = 1'b0;
    chk("off_one_push", 32'(off_empty), 32'd1);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      chk("pix_out", pix_out, 32'hA000_0000 + 32'(rid));
      rid++;
      pix_rd = 1'b1;
      tick();
    end
    pix_rd = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; frame_sel = 1'b0; continuous = 1'b0;
    busy = 1'b0; rd_data = '0; rd_valid = 1'b0; pix_rd = 1'b0; off_rd = 1'b0;

    // Reset state
    do_reset();
    chk("rst_kick", 32'(kick), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_pix_empty", 32'(pix_empty), 32'd1);
    chk("rst_off_empty", 32'(off_empty), 32'd1);
    chk("rst_pix_cnt", 32'(pix_cnt), 32'd0);

    // Single-shot frame from BASE1, second burst with a 5-cycle busy delay
    frame_sel = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("f1_active", 32'(active), 32'd1);
    serve(32'h0100_0000, 64, 0, 0);   pop_n(64);
    serve(32'h0100_0100, 64, 64, 5);  pop_n(64);
    serve(32'h0100_0200, 64, 128, 0); pop_n(64);
    serve(32'h0100_0300, 8, 192, 0);
    chk("f1_done_pulse", 32'(frame_done), 32'd1);
    tick();
    chk("f1_done_low", 32'(frame_done), 32'd0);
    chk("f1_inactive", 32'(active), 32'd0);
    pop_n(8);
    chk("f1_drained", 32'(pix_cnt), 32'd0);
    chk("f1_idle_kick", 32'(kick), 32'd0);

    // Back-pressure: no pops, FIFO fills after two bursts
    frame_sel = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    serve(32'h0000_0000, 64, 0, 0);
    serve(32'h0000_0100, 64, 64, 0);
    chk("bp_full_cnt", 32'(pix_cnt), 32'd128);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_withheld", 32'(kick), 32'd0);
    end
    pop_n(64);
    wait_kick(2);
    serve(32'h0000_0200, 64, 128, 0);
    pop_n(64);
    serve(32'h0000_0300, 8, 192, 0);
    chk("bp_done", 32'(frame_done), 32'd1);
    tick();
    pop_n(72);
    chk("bp_empty", 32'(pix_empty), 32'd1);

    // Continuous: frame_sel flips during frame 1, frame 2 uses BASE1
    continuous = 1'b1; frame_sel = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    serve(32'h0000_0000, 64, 0, 0);   pop_n(64);
    frame_sel = 1'b1;
    serve(32'h0000_0100, 64, 64, 0);  pop_n(64);
    serve(32'h0000_0200, 64, 128, 0); pop_n(64);
    serve(32'h0000_0300, 8, 192, 0);
    chk("c_done1", 32'(frame_done), 32'd1);
    tick();
    continuous = 1'b0;
    chk("c_done1_low", 32'(frame_done), 32'd0);
    chk("c_still_active", 32'(active), 32'd1);
    pop_n(8);
    serve(32'h0100_0000, 64, 0, 0);   pop_n(64);
    chk("c_active_f2", 32'(active), 32'd1);
    serve(32'h0100_0100, 64, 64, 0);  pop_n(64);
    serve(32'h0100_0200, 64, 128, 0); pop_n(64);
    serve(32'h0100_0300, 8, 192, 0);
    chk("c_done2", 32'(frame_done), 32'd1);
    tick();
    chk("c_inactive", 32'(active), 32'd0);
    pop_n(8);

    // Error conditions, each isolated by a reset
    chk("e_clean", 32'(err), 32'd0);
    rd_data = 32'hDEAD_BEEF; rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
    chk("e_idle_valid", 32'(err), 32'd1);
    chk("e_cnt_same", 32'(pix_cnt), 32'd0);
    tick();
    tick();
    chk("e_sticky", 32'(err), 32'd1);
    do_reset();
    chk("e_rst_clear", 32'(err), 32'd0);
    pix_rd = 1'b1;
    tick();
    pix_rd = 1'b0;
    chk("e_pix_underflow", 32'(err), 32'd1);
    chk("e_pix_cnt", 32'(pix_cnt), 32'd0);
    do_reset();
    chk("e_rst_clear2", 32'(err), 32'd0);
    off_rd = 1'b1;
    tick();
    off_rd = 1'b0;
    chk("e_off_underflow", 32'(err), 32'd1);
    do_reset();

    // Reset in the middle of a burst, late data afterwards
    frame_sel = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_kick(20);
    busy = 1'b1;
    tick();
    busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rd_data = 32'h5000_0000 + 32'(i);
      rd_valid = 1'b1;
      tick();
    end
    rd_valid = 1'b0;
    chk("m_cnt20", 32'(pix_cnt), 32'd20);
    rst = 1'b1;
    tick();
    chk("m_kick", 32'(kick), 32'd0);
    chk("m_pix_cnt", 32'(pix_cnt), 32'd0);
    chk("m_off_empty", 32'(off_empty), 32'd1);
    chk("m_active", 32'(active), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_valid = 1'b1;
      tick();
    end
    rd_valid = 1'b0;
    chk("m_late_no_err", 32'(err), 32'd0);
    chk("m_late_dropped", 32'(pix_cnt), 32'd0);
    frame_sel = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_kick(5);
    chk("m_restart_addr", read_addr, 32'h0100_0000);
    chk("m_restart_num", read_num, 32'd64);
    do_reset();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
